router_dest_ctrl: RTL and testbench

Destination controller for the 1x3 router. It sits between router_fsm and the three output FIFOs.
- Latches the packet's destination address.
- Steers the FSM's write enable to one FIFO and returns that FIFO's full flag to the FSM.
- Drives per-port vld_out.
- Runs a per-port read watchdog that soft-resets a FIFO its consumer has abandoned.

---
 rtl/router_pkg.sv | 26 ++
 rtl/router_timeout_wdog.sv | 41 ++++
 rtl/router_dest_ctrl.sv | 93 +++++++++
 tb/tb_router_dest_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router destination controller.
// Address encoding, port indices and the one-hot destination decode.
package router_pkg;

  localparam int NUM_PORTS       = 3;
  localparam int TIMEOUT_DEFAULT = 30;
  localparam int CNT_W_DEFAULT   = 5;

  localparam logic [1:0] ADDR_INVALID = 2'b11;
  localparam logic [1:0] PORT0        = 2'b00;
  localparam logic [1:0] PORT1        = 2'b01;
  localparam logic [1:0] PORT2        = 2'b10;

  // The reserved address matches no port, so it decodes to all zeros.
  function automatic logic [NUM_PORTS-1:0] dest_onehot(
    input logic [1:0] d
  );
    logic [NUM_PORTS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      oh[i] = (d == 2'(i));
    end
    return oh;
  endfunction

endpackage

// File: rtl/router_timeout_wdog.sv
// Per-port read watchdog: pulses soft_reset for one cycle after
// TIMEOUT consecutive cycles of valid data that nobody reads.
module router_timeout_wdog #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;
  logic             stall;

  assign stall = vld & ~rd;

  // The pulse cycle itself never counts, so a re-fire takes TIMEOUT+1 edges.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (soft_reset) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (!stall) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt        <= '0;
      soft_reset <= 1'b1;
    end else begin
      cnt        <= cnt + 1'b1;
      soft_reset <= 1'b0;
    end
  end

endmodule

// File: rtl/router_dest_ctrl.sv
// Destination controller: latches the packet address, steers writes
// and the full flag, drives vld_out and runs per-port read watchdogs.
module router_dest_ctrl
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2,
  output logic       addr_err
);

  logic [1:0]           dest;
  logic [NUM_PORTS-1:0] sel;
  logic [NUM_PORTS-1:0] full_v;
  logic [NUM_PORTS-1:0] empty_v;
  logic [NUM_PORTS-1:0] rd_v;
  logic [NUM_PORTS-1:0] vld_v;
  logic [NUM_PORTS-1:0] sr_v;

  assign full_v  = {full_2, full_1, full_0};
  assign empty_v = {empty_2, empty_1, empty_0};
  assign rd_v    = {read_enb_2, read_enb_1, read_enb_0};

  // Reset leaves dest invalid so an aborted packet is never written.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dest     <= ADDR_INVALID;
      addr_err <= 1'b0;
    end else begin
      addr_err <= detect_add && (data_in == ADDR_INVALID);
      if (detect_add) begin
        dest <= data_in;
      end
    end
  end

  assign sel = dest_onehot(dest);

  always_comb begin
    write_enb = '0;
    if (write_enb_reg) begin
      write_enb = sel;
    end
  end

  assign fifo_full = |(sel & full_v);

  assign vld_v = ~empty_v;

  assign vld_out_0 = vld_v[PORT0];
  assign vld_out_1 = vld_v[PORT1];
  assign vld_out_2 = vld_v[PORT2];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_wdog
    router_timeout_wdog #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_wdog (
      .clock      (clock),
      .resetn     (resetn),
      .vld        (vld_v[p]),
      .rd         (rd_v[p]),
      .soft_reset (sr_v[p])
    );
  end

  assign soft_reset_0 = sr_v[PORT0];
  assign soft_reset_1 = sr_v[PORT1];
  assign soft_reset_2 = sr_v[PORT2];

endmodule

// File: tb/tb_router_dest_ctrl.sv
// Self-checking bench for router_dest_ctrl: vector table for steering
// and reset, hand sequences for watchdog timeout and count restart.
module tb_router_dest_ctrl;
  import router_pkg::*;

  logic       clock = 1'b0;
  logic       resetn;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic [2:0] rd;
  logic [2:0] empty;
  logic [2:0] full;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic [2:0] vld;
  logic [2:0] sr;
  logic       addr_err;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  router_dest_ctrl dut (
    .clock         (clock),
    .resetn        (resetn),
    .detect_add    (detect_add),
    .data_in       (data_in),
    .write_enb_reg (write_enb_reg),
    .read_enb_0    (rd[0]),
    .read_enb_1    (rd[1]),
    .read_enb_2    (rd[2]),
    .empty_0       (empty[0]),
    .empty_1       (empty[1]),
    .empty_2       (empty[2]),
    .full_0        (full[0]),
    .full_1        (full[1]),
    .full_2        (full[2]),
    .write_enb     (write_enb),
    .fifo_full     (fifo_full),
    .vld_out_0     (vld[0]),
    .vld_out_1     (vld[1]),
    .vld_out_2     (vld[2]),
    .soft_reset_0  (sr[0]),
    .soft_reset_1  (sr[1]),
    .soft_reset_2  (sr[2]),
    .addr_err      (addr_err)
  );

  typedef struct {
    logic [2:0] we;
    logic       ff;
    logic [2:0] vld;
    logic [2:0] sr;
    logic       ae;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       det;
    logic [1:0] din;
    logic       wer;
    logic [2:0] rd;
    logic [2:0] emp;
    logic [2:0] full;
    logic [2:0] we;
    logic       ff;
    logic [2:0] sr;
    logic       ae;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[16];

  // Inputs are set just after a falling edge; outputs are checked
  // 2 time units later, well before the next rising edge.
  task automatic step(input string nm, input logic [2:0] we,
                      input logic ff, input logic [2:0] s,
                      input logic ae);
    exp_t e;
    e.we  = we;
    e.ff  = ff;
    e.vld = ~empty;
    e.sr  = s;
    e.ae  = ae;
    exp_q.push_back(e);
    #2;
    e = exp_q.pop_front();
    compared++;
    if ({write_enb, fifo_full, vld, sr, addr_err}
        !== {e.we, e.ff, e.vld, e.sr, e.ae}) begin
      mismatched++;
      $display("FAIL %s: got we=%b ff=%b vld=%b sr=%b ae=%b, want we=%b ff=%b vld=%b sr=%b ae=%b",
               nm, write_enb, fifo_full, vld, sr, addr_err,
               e.we, e.ff, e.vld, e.sr, e.ae);
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    resetn        = 1'b0;
    detect_add    = 1'b0;
    data_in       = 2'b00;
    write_enb_reg = 1'b0;
    rd            = 3'b000;
    empty         = 3'b111;
    full          = 3'b000;

    //          rst det din   wer rd     emp    full   we     ff sr     ae
    vecs[0]  = '{0, 0, 2'b00, 1, 3'b000, 3'b000, 3'b111, 3'b000, 0, 3'b000, 0};
    vecs[1]  = '{1, 0, 2'b00, 1, 3'b111, 3'b000, 3'b111, 3'b000, 0, 3'b000, 0};
    vecs[2]  = '{1, 1, 2'b01, 0, 3'b111, 3'b111, 3'b010, 3'b000, 0, 3'b000, 0};
    vecs[3]  = '{1, 0, 2'b00, 1, 3'b111, 3'b111, 3'b010, 3'b010, 1, 3'b000, 0};
    vecs[4]  = '{1, 0, 2'b00, 1, 3'b111, 3'b111, 3'b000, 3'b010, 0, 3'b000, 0};
    vecs[5]  = '{1, 1, 2'b11, 1, 3'b111, 3'b111, 3'b111, 3'b010, 1, 3'b000, 0};
    vecs[6]  = '{1, 0, 2'b00, 1, 3'b111, 3'b111, 3'b111, 3'b000, 0, 3'b000, 1};
    vecs[7]  = '{1, 0, 2'b00, 1, 3'b111, 3'b111, 3'b111, 3'b000, 0, 3'b000, 0};
    vecs[8]  = '{1, 1, 2'b00, 0, 3'b111, 3'b111, 3'b000, 3'b000, 0, 3'b000, 0};
    vecs[9]  = '{1, 0, 2'b00, 1, 3'b111, 3'b111, 3'b001, 3'b001, 1, 3'b000, 0};
    vecs[10] = '{1, 1, 2'b10, 1, 3'b111, 3'b111, 3'b000, 3'b001, 0, 3'b000, 0};
    vecs[11] = '{1, 0, 2'b00, 1, 3'b111, 3'b111, 3'b100, 3'b100, 1, 3'b000, 0};
    vecs[12] = '{0, 0, 2'b00, 1, 3'b111, 3'b000, 3'b111, 3'b000, 0, 3'b000, 0};
    vecs[13] = '{1, 0, 2'b00, 1, 3'b111, 3'b000, 3'b111, 3'b000, 0, 3'b000, 0};
    vecs[14] = '{1, 1, 2'b01, 1, 3'b111, 3'b000, 3'b111, 3'b000, 0, 3'b000, 0};
    vecs[15] = '{1, 0, 2'b00, 1, 3'b111, 3'b000, 3'b010, 3'b010, 1, 3'b000, 0};

    @(negedge clock);

    foreach (vecs[i]) begin
      resetn        = vecs[i].rst;
      detect_add    = vecs[i].det;
      data_in       = vecs[i].din;
      write_enb_reg = vecs[i].wer;
      rd            = vecs[i].rd;
      empty         = vecs[i].emp;
      full          = vecs[i].full;
      step($sformatf("vec%0d", i), vecs[i].we, vecs[i].ff,
           vecs[i].sr, vecs[i].ae);
    end

    // Port 2 abandoned: fires after edge 30, re-fires after edge 61.
    detect_add    = 1'b0;
    data_in       = 2'b00;
    write_enb_reg = 1'b0;
    full          = 3'b000;
    rd            = 3'b000;
    empty         = 3'b011;
    for (int k = 0; k <= 62; k++) begin
      step($sformatf("timeout2_k%0d", k), 3'b000, 1'b0,
           (k == 30 || k == 61) ? 3'b100 : 3'b000, 1'b0);
    end

    empty = 3'b111;
    step("idle", 3'b000, 1'b0, 3'b000, 1'b0);

    // Port 0: a read on the last stall cycle restarts the count.
    empty = 3'b110;
    rd    = 3'b000;
    for (int j = 0; j < 29; j++) begin
      step($sformatf("restart0_pre%0d", j), 3'b000, 1'b0, 3'b000, 1'b0);
    end
    rd = 3'b001;
    step("restart0_read", 3'b000, 1'b0, 3'b000, 1'b0);
    rd = 3'b000;
    for (int k = 0; k <= 30; k++) begin
      step($sformatf("restart0_k%0d", k), 3'b000, 1'b0,
           (k == 30) ? 3'b001 : 3'b000, 1'b0);
    end

    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard: %0d entries left, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
